// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, access lengths and constants for mem_ctrl.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INST_RD,
        S_DATA_RD,
        S_DATA_WR,
        S_IO_WAIT
    } state_t;

    localparam logic [2:0]  LEN_B           = 3'd1;
    localparam logic [2:0]  LEN_H           = 3'd2;
    localparam logic [2:0]  LEN_W           = 3'd4;
    localparam int          IO_ADDR_BIT_DEF = 17;
    localparam logic [31:0] ZeroWord        = 32'h0000_0000;

    // Anything other than a byte or halfword is serviced as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        return (len == LEN_B || len == LEN_H) ? len : LEN_W;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves icache fetches and MEM loads/stores over the byte-wide RAM, data first.
// Define MEMCTRL_IO_STALL_EN to add io_buffer_full back-pressure on IO-region stores.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int IO_ADDR_BIT = IO_ADDR_BIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_require_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic                  inst_busy_o,
    output logic                  inst_enable_o,
    output logic [31:0]           inst_data_o,
    input  logic                  data_require_i,
    input  logic                  data_we_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [2:0]            data_len_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_busy_o,
    output logic                  data_enable_o,
    output logic [31:0]           data_rdata_o,
`ifdef MEMCTRL_IO_STALL_EN
    input  logic                  io_buffer_full,
`endif
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [2:0]            r_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [31:0]           r_wdata;
    logic [31:0]           r_buf;
    logic [31:0]           r_inst_data;
    logic [31:0]           r_data_rdata;
    logic [7:0]            r_mem_dout;
    logic                  r_busy;
    logic                  r_inst_en;
    logic                  r_data_en;
    logic                  r_mem_wr;

    logic [ADDR_WIDTH-1:0] w_addr_cur;
    logic [31:0]           w_word;
    logic [7:0]            w_wbyte;
    logic                  w_io_acc;
    logic                  w_io_cur;
    logic                  w_full;

    // r_cnt is the byte index being read back (reads) or the next byte to write (stores).
    assign w_addr_cur = r_addr + ADDR_WIDTH'(r_cnt);
    assign w_word     = r_buf | (32'(mem_din) << {r_cnt[1:0], 3'b000});
    assign w_wbyte    = 8'(r_wdata >> {r_cnt[1:0], 3'b000});

`ifdef MEMCTRL_IO_STALL_EN
    assign w_io_acc = data_addr_i[IO_ADDR_BIT];
    assign w_io_cur = r_addr[IO_ADDR_BIT];
    assign w_full   = io_buffer_full;
`else
    assign w_io_acc = 1'b0;
    assign w_io_cur = 1'b0;
    assign w_full   = 1'b0;
`endif

    assign inst_busy_o   = r_busy;
    assign data_busy_o   = r_busy;
    assign inst_enable_o = r_inst_en;
    assign data_enable_o = r_data_en;
    assign inst_data_o   = r_inst_data;
    assign data_rdata_o  = r_data_rdata;
    assign mem_dout      = r_mem_dout;
    assign mem_a         = r_mem_a;
    assign mem_wr        = r_mem_wr;

    // Arbitration plus byte sequencing; one counter walks every transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_addr       <= '0;
            r_mem_a      <= '0;
            r_wdata      <= ZeroWord;
            r_buf        <= ZeroWord;
            r_inst_data  <= ZeroWord;
            r_data_rdata <= ZeroWord;
            r_mem_dout   <= '0;
            r_busy       <= 1'b0;
            r_inst_en    <= 1'b0;
            r_data_en    <= 1'b0;
            r_mem_wr     <= 1'b0;
        end else begin
            r_inst_en <= 1'b0;
            r_data_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_buf <= ZeroWord;
                    if (data_require_i) begin
                        r_addr  <= data_addr_i;
                        r_len   <= norm_len(data_len_i);
                        r_wdata <= data_wdata_i;
                        r_mem_a <= data_addr_i;
                        r_busy  <= 1'b1;
                        if (!data_we_i) begin
                            r_state <= S_DATA_RD;
                        end else if (w_io_acc && w_full) begin
                            r_state <= S_IO_WAIT;
                        end else begin
                            r_mem_dout <= data_wdata_i[7:0];
                            r_mem_wr   <= 1'b1;
                            r_cnt      <= 3'd1;
                            r_state    <= S_DATA_WR;
                        end
                    end else if (inst_require_i) begin
                        r_addr  <= inst_addr_i;
                        r_len   <= LEN_W;
                        r_mem_a <= inst_addr_i;
                        r_busy  <= 1'b1;
                        r_state <= S_INST_RD;
                    end
                end
                S_INST_RD, S_DATA_RD: begin
                    r_buf <= w_word;
                    if (r_cnt == r_len - 3'd1) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (r_state == S_INST_RD) begin
                            r_inst_data <= w_word;
                            r_inst_en   <= 1'b1;
                        end else begin
                            r_data_rdata <= w_word;
                            r_data_en    <= 1'b1;
                        end
                    end else begin
                        r_mem_a <= w_addr_cur + ADDR_WIDTH'(1);
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end
                S_DATA_WR: begin
                    if (r_cnt == r_len) begin
                        r_mem_wr  <= 1'b0;
                        r_data_en <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_io_cur) begin
                        r_mem_wr <= 1'b0;
                        r_state  <= S_IO_WAIT;
                    end else begin
                        r_mem_a    <= w_addr_cur;
                        r_mem_dout <= w_wbyte;
                        r_cnt      <= r_cnt + 3'd1;
                    end
                end
                S_IO_WAIT: begin
                    if (!w_full) begin
                        r_mem_a    <= w_addr_cur;
                        r_mem_dout <= w_wbyte;
                        r_mem_wr   <= 1'b1;
                        r_cnt      <= r_cnt + 3'd1;
                        r_state    <= S_DATA_WR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Flag unsupported byte counts at acceptance and an IO bit outside the address bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (IO_ADDR_BIT < ADDR_WIDTH);
            if (r_state == S_IDLE && data_require_i)
                assert (data_len_i inside {LEN_B, LEN_H, LEN_W});
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed table, corner sequences and random traffic against a byte-memory model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_require_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_busy_o, inst_enable_o;
    logic [31:0] inst_data_o;
    logic        data_require_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic [2:0]  data_len_i = 3'd4;
    logic [31:0] data_wdata_i = '0;
    logic        data_busy_o, data_enable_o;
    logic [31:0] data_rdata_o;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef MEMCTRL_IO_STALL_EN
    logic        io_full = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .inst_require_i(inst_require_i), .inst_addr_i(inst_addr_i),
        .inst_busy_o(inst_busy_o), .inst_enable_o(inst_enable_o), .inst_data_o(inst_data_o),
        .data_require_i(data_require_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_len_i(data_len_i), .data_wdata_i(data_wdata_i),
        .data_busy_o(data_busy_o), .data_enable_o(data_enable_o), .data_rdata_o(data_rdata_o),
`ifdef MEMCTRL_IO_STALL_EN
        .io_buffer_full(io_full),
`endif
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    // Physical RAM seen on the bus, and the expected contents kept at transaction level.
    bit [7:0] phys  [bit [31:0]];
    bit [7:0] model [bit [31:0]];

    function automatic bit [7:0] dflt(input bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction
    function automatic bit [7:0] phys_rd(input bit [31:0] a);
        return phys.exists(a) ? phys[a] : dflt(a);
    endfunction
    function automatic bit [7:0] model_rd(input bit [31:0] a);
        return model.exists(a) ? model[a] : dflt(a);
    endfunction

    logic [31:0] a_log [$];
    logic [39:0] wr_log [$];
    int ie_cnt = 0;
    int de_cnt = 0;

    // RAM behaviour and bus monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (mem_wr) begin
            phys[mem_a] = mem_dout;
            wr_log.push_back({mem_a, mem_dout});
        end
        if (inst_busy_o) a_log.push_back(mem_a);
        ie_cnt += int'(inst_enable_o);
        de_cnt += int'(data_enable_o);
        mem_din = phys_rd(mem_a);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        phys[a]  = b;
        model[a] = b;
    endtask

    task automatic wait_pulse(input int i0, input int d0, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk); #1;
            if (ie_cnt != i0 || de_cnt != d0) break;
            cyc++;
        end
    endtask

    task automatic txn(input bit d, input bit we, input logic [31:0] addr, input logic [2:0] len,
                       input logic [31:0] wd, input bit chk, input logic [31:0] exp);
        int a0, w0, i0, d0, cyc, lat;
        logic [31:0] m;
        bit ok;
        @(negedge clk); #1;
        a0 = a_log.size(); w0 = wr_log.size(); i0 = ie_cnt; d0 = de_cnt;
        if (d) begin
            data_require_i = 1'b1; data_we_i = we; data_addr_i = addr;
            data_len_i = len; data_wdata_i = wd;
        end else begin
            inst_require_i = 1'b1; inst_addr_i = addr;
        end
        @(posedge clk); #1;
        data_require_i = 1'b0; inst_require_i = 1'b0;
        data_we_i = 1'($urandom); data_addr_i = $urandom; data_wdata_i = $urandom;
        inst_addr_i = $urandom; data_len_i = 3'd4;
        check("busy_on", {inst_busy_o, data_busy_o}, 2'b11);
        wait_pulse(i0, d0, cyc);
        lat = int'(len);
`ifdef MEMCTRL_IO_STALL_EN
        if (d && we && addr[IO_ADDR_BIT_DEF]) lat = 2 * int'(len) - 1;
`endif
        check("latency", 64'(cyc), 64'(lat));
        check("inst_pulses", 64'(ie_cnt - i0), d ? 64'd0 : 64'd1);
        check("data_pulses", 64'(de_cnt - d0), d ? 64'd1 : 64'd0);
        if (d && we) begin
            ok = (wr_log.size() - w0 == int'(len));
            for (int i = 0; i < int'(len); i++) begin
                if (ok && wr_log[w0 + i] != {addr + 32'(i), wd[8*i +: 8]}) ok = 1'b0;
                model[addr + 32'(i)] = wd[8*i +: 8];
            end
            check("wr_seq", 64'(ok), 64'd1);
        end else begin
            m = '0;
            for (int i = 0; i < int'(len); i++) m |= 32'(model_rd(addr + 32'(i))) << (8 * i);
            check(d ? "rdata" : "inst_data", d ? data_rdata_o : inst_data_o, chk ? exp : m);
            ok = (a_log.size() - a0 == int'(len));
            for (int i = 0; i < int'(len); i++)
                if (ok && a_log[a0 + i] != addr + 32'(i)) ok = 1'b0;
            check("rd_addr_seq", 64'(ok), 64'd1);
        end
        @(negedge clk); #1;
        check("pulse_1cyc", 64'((ie_cnt - i0) + (de_cnt - d0)), 64'd1);
        check("idle_after", {inst_busy_o, data_busy_o, mem_wr, inst_enable_o, data_enable_o}, 5'b0);
    endtask

    typedef struct {
        bit          d;
        bit          we;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        int i0, d0, w0, cyc, k, pick;
        logic [31:0] addr;
        logic [2:0]  len;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 3'd4, 32'h0,         32'h0000_0513};
        vt[1] = '{1'b1, 1'b0, 32'h0000_1000, 3'd4, 32'h0,         32'hDEAD_BEEF};
        vt[2] = '{1'b1, 1'b1, 32'h0000_FFFF, 3'd2, 32'h1234_ABCD, 32'h0};
        vt[3] = '{1'b1, 1'b0, 32'h0000_FFFF, 3'd2, 32'h0,         32'h0000_ABCD};
        vt[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 3'd1, 32'h0,         32'h0000_009C};
        vt[5] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0,         32'h4433_9C11};
        vt[6] = '{1'b1, 1'b1, 32'h0000_4000, 3'd1, 32'hFFFF_FF77, 32'h0};
        vt[7] = '{1'b1, 1'b0, 32'h0000_4000, 3'd4, 32'h0,         32'h0000_0077};

        preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'h1000, 8'hEF); preload(32'h1001, 8'hBE); preload(32'h1002, 8'hAD); preload(32'h1003, 8'hDE);
        preload(32'h200, 8'h93); preload(32'h201, 8'h00); preload(32'h202, 8'h10); preload(32'h203, 8'h00);
        preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h9C); preload(32'h0, 8'h33); preload(32'h1, 8'h44);
        preload(32'h4001, 8'h00); preload(32'h4002, 8'h00); preload(32'h4003, 8'h00);

        repeat (3) @(negedge clk);
        check("rst_ctrl", {inst_busy_o, data_busy_o, inst_enable_o, data_enable_o, mem_wr}, 5'b0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_dout", mem_dout, 8'h0);
        check("rst_words", {inst_data_o, data_rdata_o}, 64'h0);
        rst = 1'b1;

        for (int v = 0; v < 8; v++)
            txn(vt[v].d, vt[v].we, vt[v].addr, vt[v].len, vt[v].wd, 1'b1, vt[v].exp);

        // Same-edge requests: the load goes first, the fetch waits at its level.
        @(negedge clk); #1;
        i0 = ie_cnt; d0 = de_cnt;
        data_require_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h1000; data_len_i = 3'd4;
        inst_require_i = 1'b1; inst_addr_i = 32'h200;
        @(posedge clk); #1;
        data_require_i = 1'b0;
        wait_pulse(i0, d0, cyc);
        check("sim_data_lat", 64'(cyc), 64'd4);
        check("sim_data_first", 64'(de_cnt - d0), 64'd1);
        check("sim_inst_waits", 64'(ie_cnt - i0), 64'd0);
        check("sim_rdata", data_rdata_o, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        inst_require_i = 1'b0;
        d0 = de_cnt;
        wait_pulse(i0, d0, cyc);
        check("sim_inst_lat", 64'(cyc), 64'd4);
        check("sim_inst_data", inst_data_o, 32'h0010_0093);

        // Reset landing on the third edge of a word store aborts it silently.
        @(negedge clk); #1;
        i0 = ie_cnt; d0 = de_cnt; w0 = wr_log.size();
        data_require_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h2000;
        data_len_i = 3'd4; data_wdata_i = 32'h1122_3344;
        @(posedge clk); #1;
        data_require_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_idle", {mem_wr, inst_busy_o, data_busy_o}, 3'b0);
        repeat (5) @(negedge clk);
        #1;
        check("abort_no_pulse", 64'((ie_cnt - i0) + (de_cnt - d0)), 64'd0);
        check("abort_writes", 64'(wr_log.size() - w0), 64'd2);
        txn(1'b1, 1'b0, 32'h1000, 3'd4, 32'h0, 1'b1, 32'hDEAD_BEEF);

`ifdef MEMCTRL_IO_STALL_EN
        // IO byte store held off by a full buffer for three sampled edges.
        @(negedge clk); #1;
        i0 = ie_cnt; d0 = de_cnt; w0 = wr_log.size();
        io_full = 1'b1;
        data_require_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h3_0000;
        data_len_i = 3'd1; data_wdata_i = 32'h5A;
        @(posedge clk); #1;
        data_require_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        io_full = 1'b0;
        @(negedge clk); #1;
        check("io_stalled", 64'(wr_log.size() - w0), 64'd0);
        wait_pulse(i0, d0, cyc);
        check("io_lat", 64'(cyc), 64'd1);
        check("io_write", (wr_log.size() - w0 == 1) ? 64'(wr_log[w0]) : 64'hBAD, {32'h3_0000, 8'h5A});
        model[32'h3_0000] = 8'h5A;
`endif

        for (int n = 0; n < 80; n++) begin
            k = int'($urandom_range(0, 2));
            pick = int'($urandom_range(0, 2));
            len = (pick == 0) ? 3'd1 : (pick == 1) ? 3'd2 : 3'd4;
            addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : 32'h4000 + 32'($urandom_range(0, 63));
            if (k == 0) txn(1'b0, 1'b0, addr, 3'd4, 32'h0, 1'b0, 32'h0);
            else        txn(1'b1, k == 2, addr, len, $urandom, 1'b0, 32'h0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
